// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice, a carry flop and operand shift registers,
// LSB first. Operands are captured on start; the result is published with a one-cycle done pulse.
module serial_adder #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-2:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;

    logic             sum_bit;
    logic             carry;
    logic             accept;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        state_d  = state_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        s_d      = s_q;
        cout_d   = cout_q;
        accept   = 1'b0;
        sum_bit  = ra_q[0] ^ rb_q[0] ^ c_q;
        carry    = (ra_q[0] & rb_q[0]) | (ra_q[0] & c_q) | (rb_q[0] & c_q);
        // Accumulator keeps only the upper WIDTH-1 sum bits; the full word exists for one step.
        acc_next = {sum_bit, acc_q};

        unique case (state_q)
            StIdle: begin
                accept = start;
            end
            StShift: begin
                ra_d  = {1'b0, ra_q[WIDTH-1:1]};
                rb_d  = {1'b0, rb_q[WIDTH-1:1]};
                acc_d = acc_next[WIDTH-1:1];
                c_d   = carry;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LastCnt) begin
                    s_d     = acc_next;
                    cout_d  = carry;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                accept = start;
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            ra_d    = A;
            rb_d    = B;
            c_d     = Cin;
            cnt_d   = '0;
            acc_d   = '0;
            busy_d  = 1'b1;
            state_d = StShift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ra_q    <= '0;
            rb_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, hand sequences for multi-cycle corners,
// and a scoreboard queue popped whenever done pulses.
module tb_serial_adder;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         cout;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin_in;
    logic         busy;
    logic         done;
    logic [W-1:0] s_out;
    logic         cout_out;

    int pass_cnt;
    int total_cnt;
    int done_seen;

    logic [W:0] exp_q[$];

    serial_adder #(
        .WIDTH(W),
        .CNT_W(5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .A    (a_in),
        .B    (b_in),
        .Cin  (cin_in),
        .busy (busy),
        .done (done),
        .S    (s_out),
        .Cout (cout_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("sb_result", {27'd0, cout_out, s_out}, {27'd0, e});
            end
        end
    end

    // Drive one start pulse at a falling edge; accepted at the next rising edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W:0] exp);
        a_in   = a;
        b_in   = b;
        cin_in = c;
        start  = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_timeout", exp_q.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    vec_t vecs[7];

    initial begin
        int d0;
        pass_cnt  = 0;
        total_cnt = 0;
        done_seen = 0;
        vecs[0] = '{a: 4'd5, b: 4'd3, cin: 1'b0, s: 4'd8, cout: 1'b0};
        vecs[1] = '{a: 4'hF, b: 4'h1, cin: 1'b0, s: 4'h0, cout: 1'b1};
        vecs[2] = '{a: 4'hF, b: 4'hF, cin: 1'b1, s: 4'hF, cout: 1'b1};
        vecs[3] = '{a: 4'h0, b: 4'h0, cin: 1'b1, s: 4'h1, cout: 1'b0};
        vecs[4] = '{a: 4'd3, b: 4'd4, cin: 1'b0, s: 4'd7, cout: 1'b0};
        vecs[5] = '{a: 4'hA, b: 4'h5, cin: 1'b1, s: 4'h0, cout: 1'b1};
        vecs[6] = '{a: 4'h9, b: 4'h9, cin: 1'b0, s: 4'h2, cout: 1'b1};

        rst_n  = 1'b0;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        cin_in = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {28'd0, busy, done, cout_out, |s_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add with cycle-accurate busy/done timing.
        issue(4'd5, 4'd3, 1'b0, 5'd8);
        for (int k = 0; k < 4; k++) begin
            check("basic_busy", {30'd0, busy, done}, 32'd2);
            check("basic_s_hold", {27'd0, cout_out, s_out}, 32'd0);
            @(negedge clk);
        end
        check("basic_done", {30'd0, busy, done}, 32'd1);
        check("basic_s", {28'd0, s_out}, 32'd8);
        @(negedge clk);
        check("basic_after", {30'd0, busy, done}, 32'd0);
        wait_drain(4);

        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].s});
            wait_drain(20);
            check("vec_s", {28'd0, s_out}, {28'd0, vecs[i].s});
            check("vec_cout", {31'd0, cout_out}, {31'd0, vecs[i].cout});
        end

        // Start pulses during SHIFT must be ignored.
        d0 = done_seen;
        issue(4'd5, 4'd3, 1'b0, 5'd8);
        a_in  = 4'h9;
        b_in  = 4'h9;
        @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("lockout_dones", done_seen - d0, 32'd1);
        check("lockout_s", {28'd0, s_out}, 32'd8);
        check("lockout_idle", {31'd0, busy}, 32'd0);

        // Back-to-back: start held into the DONE cycle with new operands.
        a_in   = 4'd2;
        b_in   = 4'd2;
        cin_in = 1'b0;
        start  = 1'b1;
        exp_q.push_back(5'd4);
        repeat (4) @(negedge clk);
        @(negedge clk);
        check("b2b_done1", {30'd0, busy, done}, 32'd1);
        check("b2b_first", {27'd0, cout_out, s_out}, 32'd4);
        a_in = 4'd7;
        b_in = 4'd9;
        exp_q.push_back(5'h10);
        @(negedge clk);
        start = 1'b0;
        check("b2b_rebusy", {30'd0, busy, done}, 32'd2);
        repeat (3) @(negedge clk);
        check("b2b_gap", {30'd0, busy, done}, 32'd2);
        @(negedge clk);
        check("b2b_done2", {30'd0, busy, done}, 32'd1);
        check("b2b_second", {27'd0, cout_out, s_out}, 32'h10);
        wait_drain(4);

        // Asynchronous reset between edges mid-operation.
        issue(4'hA, 4'h5, 1'b0, 5'hF);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_outputs", {28'd0, busy, done, cout_out, |s_out}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(4'd3, 4'd4, 1'b0, 5'd7);
        wait_drain(20);
        check("arst_new", {27'd0, cout_out, s_out}, 32'd7);

        // Exhaustive, issued back-to-back by holding start into each DONE cycle.
        d0 = done_seen;
        start = 1'b1;
        for (int n = 0; n < 512; n++) begin
            logic [8:0] v;
            logic [W:0] m;
            v      = 9'(n);
            a_in   = v[8:5];
            b_in   = v[4:1];
            cin_in = v[0];
            m      = {1'b0, v[8:5]} + {1'b0, v[4:1]} + {4'd0, v[0]};
            exp_q.push_back(m);
            wait_done(W + 4);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("exh_dones", done_seen - d0, 32'd512);
        check("exh_drain", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
